// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the instruction-fetch and data
// ports. Data wins by default; a starvation counter bounds instruction waits, a watchdog aborts.
module mem_arbiter #(
  parameter int unsigned MAX_DATA = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_rd_wr,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        m_req,
  output logic        m_rd_wr,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        err
);

  localparam logic [3:0]  MaxData = 4'(MAX_DATA);
  localparam logic [7:0]  Timeout = 8'(TIMEOUT);
  localparam logic [31:0] ErrData = 32'hDEADBEEF;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic        owner_i_q, owner_i_d;
  logic        m_req_q, m_req_d;
  logic        m_rd_wr_q, m_rd_wr_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic        err_q, err_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [7:0]  wd_cnt_q, wd_cnt_d;

  logic        grant_i;
  logic        finish;
  logic [31:0] fin_data;

  always_comb begin
    state_d      = state_q;
    owner_i_d    = owner_i_q;
    m_req_d      = m_req_q;
    m_rd_wr_d    = m_rd_wr_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    err_d        = err_q;
    starve_cnt_d = starve_cnt_q;
    wd_cnt_d     = wd_cnt_q;
    grant_i      = 1'b0;
    finish       = 1'b0;
    fin_data     = m_rdata;

    case (state_q)
      StIdle: begin
        if (i_req || d_req) begin
          grant_i   = i_req && (!d_req || (starve_cnt_q >= MaxData));
          owner_i_d = grant_i;
          m_req_d   = 1'b1;
          wd_cnt_d  = 8'd0;
          state_d   = StBusy;
          if (grant_i) begin
            // Fetches are always reads; the write-data bus is parked at zero.
            m_rd_wr_d    = 1'b1;
            m_addr_d     = i_addr;
            m_wdata_d    = 32'd0;
            starve_cnt_d = 4'd0;
          end else begin
            m_rd_wr_d = d_rd_wr;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            if (!i_req) begin
              starve_cnt_d = 4'd0;
            end else if (starve_cnt_q < MaxData) begin
              starve_cnt_d = starve_cnt_q + 4'd1;
            end
          end
        end
      end
      StBusy: begin
        // A real completion in the watchdog's final cycle wins over the abort.
        if (m_ready) begin
          finish = 1'b1;
        end else if ((Timeout != 8'd0) && (wd_cnt_q == Timeout)) begin
          finish   = 1'b1;
          fin_data = ErrData;
          err_d    = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (finish) begin
      m_req_d = 1'b0;
      state_d = StDone;
      if (owner_i_q) begin
        i_rdata_d = fin_data;
        i_done_d  = 1'b1;
      end else begin
        d_done_d = 1'b1;
        if (m_rd_wr_q) begin
          d_rdata_d = fin_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_i_q    <= 1'b0;
      m_req_q      <= 1'b0;
      m_rd_wr_q    <= 1'b1;
      m_addr_q     <= 32'd0;
      m_wdata_q    <= 32'd0;
      i_rdata_q    <= 32'd0;
      d_rdata_q    <= 32'd0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      err_q        <= 1'b0;
      starve_cnt_q <= 4'd0;
      wd_cnt_q     <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_i_q    <= owner_i_d;
      m_req_q      <= m_req_d;
      m_rd_wr_q    <= m_rd_wr_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      err_q        <= err_d;
      starve_cnt_q <= starve_cnt_d;
      wd_cnt_q     <= wd_cnt_d;
    end
  end

  assign i_rdata = i_rdata_q;
  assign i_done  = i_done_q;
  assign d_rdata = d_rdata_q;
  assign d_done  = d_done_q;
  assign m_req   = m_req_q;
  assign m_rd_wr = m_rd_wr_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then random traffic,
// with every cycle compared against a transaction-level model of the arbiter.
module tb_mem_arbiter;

  localparam int unsigned MaxData = 4;
  localparam int unsigned Timeout = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_rd_wr, m_ready;
  logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
  logic        i_done, d_done, m_req, m_rd_wr, err;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_DATA(MaxData), .TIMEOUT(Timeout)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_done(i_done),
    .d_req(d_req), .d_rd_wr(d_rd_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_req(m_req), .m_rd_wr(m_rd_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one access record (owner, age in memory cycles) plus the values each
  // port must currently show.
  bit          md_busy, md_done, md_own_i;
  int unsigned md_age, md_starve;
  logic        e_m_req, e_m_rd_wr, e_i_done, e_d_done, e_err;
  logic [31:0] e_m_addr, e_m_wdata, e_i_rdata, e_d_rdata;

  task automatic model_complete(input logic [31:0] val, input bit timed_out);
    md_busy = 1'b0;
    md_done = 1'b1;
    if (timed_out) e_err = 1'b1;
    if (md_own_i) begin
      e_i_done  = 1'b1;
      e_i_rdata = val;
    end else begin
      e_d_done = 1'b1;
      if (e_m_rd_wr) e_d_rdata = val;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        md_busy = 0; md_done = 0; md_own_i = 0; md_age = 0; md_starve = 0;
        e_m_req = 0; e_m_rd_wr = 1; e_i_done = 0; e_d_done = 0; e_err = 0;
        e_m_addr = 0; e_m_wdata = 0; e_i_rdata = 0; e_d_rdata = 0;
      end else begin
        e_i_done = 0;
        e_d_done = 0;
        if (md_done) begin
          md_done = 0;
        end else if (md_busy) begin
          if (m_ready) model_complete(m_rdata, 1'b0);
          else if (Timeout != 0 && md_age == Timeout) model_complete(32'hDEADBEEF, 1'b1);
          else md_age++;
        end else if (i_req || d_req) begin
          md_own_i = i_req && !(d_req && md_starve < MaxData);
          md_busy  = 1'b1;
          md_age   = 0;
          if (md_own_i) begin
            md_starve = 0;
            e_m_rd_wr = 1'b1;
            e_m_addr  = i_addr;
            e_m_wdata = 32'd0;
          end else begin
            md_starve = i_req ? ((md_starve + 1 > MaxData) ? MaxData : md_starve + 1) : 0;
            e_m_rd_wr = d_rd_wr;
            e_m_addr  = d_addr;
            e_m_wdata = d_wdata;
          end
        end
        e_m_req = md_busy;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        chk1("m_req", m_req, e_m_req);
        chk1("m_rd_wr", m_rd_wr, e_m_rd_wr);
        chk("m_addr", m_addr, e_m_addr);
        chk("m_wdata", m_wdata, e_m_wdata);
        chk1("i_done", i_done, e_i_done);
        chk1("d_done", d_done, e_d_done);
        chk("i_rdata", i_rdata, e_i_rdata);
        chk("d_rdata", d_rdata, e_d_rdata);
        chk1("err", err, e_err);
      end
    end
  end

  // Memory responder: m_ready on busy cycle index mem_lat of each access.
  bit          rand_mem = 1'b0, rand_req = 1'b0, mreq_seen = 1'b0;
  int          mem_lat = 1000, busy_idx = 0;
  logic [31:0] mem_data = 32'd0;

  task automatic drive_mem();
    if (m_req) begin
      if (!mreq_seen) begin
        mreq_seen = 1'b1;
        busy_idx  = 0;
        if (rand_mem) mem_lat = int'($urandom_range(0, 10));
      end else begin
        busy_idx++;
      end
      m_ready = (busy_idx == mem_lat);
    end else begin
      mreq_seen = 1'b0;
      m_ready   = rand_mem && ($urandom_range(0, 7) == 0);
    end
    m_rdata = rand_mem ? $urandom : mem_data;
  endtask

  task automatic drive_req();
    if (!i_req) begin
      if ($urandom_range(0, 2) == 0) begin i_req = 1'b1; i_addr = $urandom; end
    end else if (i_done) begin
      if ($urandom_range(0, 1) == 0) i_addr = $urandom;
      else i_req = 1'b0;
    end
    if (!d_req) begin
      if ($urandom_range(0, 1) == 0) begin
        d_req = 1'b1; d_rd_wr = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
      end
    end else if (d_done) begin
      if ($urandom_range(0, 2) != 0) begin
        d_rd_wr = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
      end else begin
        d_req = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_mem();
    if (rand_req) drive_req();
  endtask

  task automatic wait_done(input bit want_i, input int bound, output int cyc);
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!(want_i ? i_done : d_done) && cyc < bound);
    if (!(want_i ? i_done : d_done)) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_done: no completion within %0d cycles at %0t", bound, $time);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: bench did not finish");
    $fatal(1);
  end

  initial begin
    int    c;
    string exp_order;
    string got;
    reset = 1'b0; i_req = 0; d_req = 0; d_rd_wr = 1; m_ready = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    chk1("reset m_req", m_req, 1'b0);
    chk1("reset m_rd_wr", m_rd_wr, 1'b1);
    chk1("reset err", err, 1'b0);
    chk("reset d_rdata", d_rdata, 32'd0);
    step();
    reset = 1'b1;
    step();

    // Single instruction read, memory ready in the first busy cycle.
    i_req = 1; i_addr = 32'h100; mem_lat = 0; mem_data = 32'h8C220004;
    step();
    chk1("ifetch m_req", m_req, 1'b1);
    chk1("ifetch m_rd_wr", m_rd_wr, 1'b1);
    chk("ifetch m_addr", m_addr, 32'h100);
    step();
    chk1("ifetch i_done", i_done, 1'b1);
    chk("ifetch i_rdata", i_rdata, 32'h8C220004);
    chk1("ifetch m_req low", m_req, 1'b0);
    i_req = 0;
    step();
    chk1("ifetch done pulse", i_done, 1'b0);

    // Data write with three wait cycles.
    d_req = 1; d_rd_wr = 0; d_addr = 32'h2000; d_wdata = 32'hCAFEF00D; mem_lat = 3;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("write m_wdata", m_wdata, 32'hCAFEF00D);
      chk1("write m_rd_wr", m_rd_wr, 1'b0);
      chk1("write m_req", m_req, 1'b1);
    end
    step();
    chk1("write d_done", d_done, 1'b1);
    chk("write d_rdata kept", d_rdata, 32'd0);
    d_req = 0;
    step();

    // Starvation bound with both requesters held.
    exp_order = "DDDDIDDDDI";
    got = "";
    i_req = 1; i_addr = 32'h400; d_req = 1; d_rd_wr = 1; d_addr = 32'h5000;
    mem_lat = 0; mem_data = 32'h1111;
    for (int k = 0; k < 100 && got.len() < 10; k++) begin
      step();
      if (i_done) got = {got, "I"};
      if (d_done) got = {got, "D"};
    end
    i_req = 0; d_req = 0;
    chk("starve completions", 32'(got.len()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("grant_order[%0d]", k), (k < got.len()) ? 32'(got[k]) : 32'd0,
          32'(exp_order[k]));
    end
    step();

    // m_ready in the watchdog's final cycle: real data wins.
    i_req = 1; i_addr = 32'h700; mem_lat = 8; mem_data = 32'h13579BDF;
    wait_done(1'b1, 30, c);
    chk("race latency", 32'(c), 32'd10);
    chk("race i_rdata", i_rdata, 32'h13579BDF);
    chk1("race err", err, 1'b0);
    i_req = 0;
    step();

    // Timeout on a data read.
    d_req = 1; d_rd_wr = 1; d_addr = 32'h3000; mem_lat = 1000;
    wait_done(1'b0, 30, c);
    chk("timeout latency", 32'(c), 32'd10);
    chk("timeout d_rdata", d_rdata, 32'hDEADBEEF);
    chk1("timeout err", err, 1'b1);
    d_addr = 32'h3004; mem_lat = 1; mem_data = 32'h12345678;
    step();
    chk1("err sticky", err, 1'b1);
    wait_done(1'b0, 30, c);
    chk("after timeout d_rdata", d_rdata, 32'h12345678);
    chk1("after timeout err", err, 1'b1);
    d_req = 0;
    step();

    // Reset in the middle of an access.
    i_req = 1; i_addr = 32'h600; mem_lat = 1000;
    step();
    step();
    chk1("pre-reset m_req", m_req, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("mid-reset m_req", m_req, 1'b0);
    chk1("mid-reset m_rd_wr", m_rd_wr, 1'b1);
    chk1("mid-reset err", err, 1'b0);
    chk1("mid-reset i_done", i_done, 1'b0);
    step();
    step();
    #3 reset = 1'b1;
    mem_lat = 0; mem_data = 32'h24420001;
    wait_done(1'b1, 10, c);
    chk("post-reset latency", 32'(c), 32'd2);
    chk("post-reset i_rdata", i_rdata, 32'h24420001);
    i_req = 0;
    step();

    // Random traffic against the model.
    rand_mem = 1'b1;
    rand_req = 1'b1;
    repeat (3000) step();
    rand_req = 1'b0;
    i_req = 0;
    d_req = 0;
    repeat (15) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
